// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control FSM; MC_CTRL_IMM_CMP_EN adds slti/sltiu
// Sequences fetch/decode/execute/memory/writeback with SRAM ack timeouts.
module mc_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       inst_ok,
  input  logic       data_ok,
  output logic       inst_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] ext_type,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic       data_req,
  output logic       data_wr,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       wb_sel,
  output logic       ri_excp,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {C_ALU, C_MEM, C_BR, C_J, C_ILL} cls_t;

`ifdef MC_CTRL_IMM_CMP_EN
  localparam bit IMM_CMP_EN = 1'b1;
`else
  localparam bit IMM_CMP_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4, ALU_SLTU = 4'd5, ALU_PASSB = 4'd6;

  localparam logic [1:0] EXT_SIGN = 2'b00, EXT_ZERO = 2'b01, EXT_LUI = 2'b10;
  localparam logic [1:0] PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JMP = 2'b10, PC_EXC = 2'b11;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cls_t       dec_cls;
  logic [1:0] dec_ext;
  logic       dec_srcb;
  logic [3:0] dec_aop;
  logic       timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction class plus the ALU-side controls EXEC/MEM/WB all share.
  always_comb begin
    dec_cls  = C_ALU;
    dec_ext  = EXT_SIGN;
    dec_srcb = 1'b1;
    dec_aop  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        dec_srcb = 1'b0;
        case (funct)
          F_ADDU:  dec_aop = ALU_ADD;
          F_SUBU:  dec_aop = ALU_SUB;
          F_AND:   dec_aop = ALU_AND;
          F_OR:    dec_aop = ALU_OR;
          F_SLT:   dec_aop = ALU_SLT;
          F_SLTU:  dec_aop = ALU_SLTU;
          default: dec_cls = C_ILL;
        endcase
      end
      OP_ADDIU: dec_aop = ALU_ADD;
      OP_ANDI: begin
        dec_ext = EXT_ZERO;
        dec_aop = ALU_AND;
      end
      OP_ORI: begin
        dec_ext = EXT_ZERO;
        dec_aop = ALU_OR;
      end
      OP_LUI: begin
        dec_ext = EXT_LUI;
        dec_aop = ALU_PASSB;
      end
      // sltiu still sign-extends its immediate, as MIPS defines it
      OP_SLTI: begin
        dec_aop = ALU_SLT;
        if (!IMM_CMP_EN) dec_cls = C_ILL;
      end
      OP_SLTIU: begin
        dec_aop = ALU_SLTU;
        if (!IMM_CMP_EN) dec_cls = C_ILL;
      end
      OP_LW, OP_SW: dec_cls = C_MEM;
      OP_BEQ, OP_BNE: begin
        dec_cls  = C_BR;
        dec_srcb = 1'b0;
        dec_aop  = ALU_SUB;
      end
      OP_J:    dec_cls = C_J;
      default: dec_cls = C_ILL;
    endcase
  end

  assign timeout = (cnt_q == TO_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    inst_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    ext_type  = EXT_SIGN;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    data_req  = 1'b0;
    data_wr   = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 1'b0;
    ri_excp   = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        inst_req = 1'b1;
        if (inst_ok) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_SEQ;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_EXC;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_J: begin
            pc_we   = 1'b1;
            pc_src  = PC_JMP;
            state_d = S_FETCH;
          end
          C_ILL:   state_d = S_TRAP;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ext_type  = dec_ext;
        alu_src_b = dec_srcb;
        alu_op    = dec_aop;
        case (dec_cls)
          C_MEM: state_d = S_MEM;
          C_BR: begin
            pc_src  = PC_BR;
            pc_we   = (op == OP_BEQ) ? zero : ~zero;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        ext_type  = dec_ext;
        alu_src_b = dec_srcb;
        alu_op    = dec_aop;
        data_req  = 1'b1;
        data_wr   = (op == OP_SW);
        if (data_ok) begin
          state_d = (op == OP_SW) ? S_FETCH : S_WB;
        end else if (timeout) begin
          bus_err = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_EXC;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        ext_type  = dec_ext;
        alu_src_b = dec_srcb;
        alu_op    = dec_aop;
        reg_we    = 1'b1;
        reg_dst   = (op == OP_RTYPE);
        wb_sel    = (op == OP_LW);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        ri_excp = 1'b1;
        pc_we   = 1'b1;
        pc_src  = PC_EXC;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a table-driven model
// Build with or without MC_CTRL_IMM_CMP_EN to match the DUT.
module tb_mc_ctrl;

  localparam int TO = 4;
  localparam int K_ALU = 0, K_MEM = 1, K_BR = 2, K_J = 3, K_ILL = 4;

  typedef struct packed {
    logic       ireq, irwe, pcwe;
    logic [1:0] pcs, ext;
    logic       srcb;
    logic [3:0] aop;
    logic       dreq, dwr, rwe, rdst, wsel, ri, be;
  } out_t;

  typedef struct {
    logic [5:0] rop, rfn;
    int         kind;
    logic [1:0] ext;
    logic       srcb;
    logic [3:0] aop;
  } row_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] op, funct;
  logic       zero, inst_ok, data_ok;
  logic       inst_req, ir_we, pc_we, alu_src_b, data_req, data_wr;
  logic       reg_we, reg_dst, wb_sel, ri_excp, bus_err;
  logic [1:0] pc_src, ext_type;
  logic [3:0] alu_op;
  out_t       obs;
  row_t       tbl[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .op(op), .funct(funct), .zero(zero),
    .inst_ok(inst_ok), .data_ok(data_ok), .inst_req(inst_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .ext_type(ext_type), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .data_req(data_req), .data_wr(data_wr), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .ri_excp(ri_excp), .bus_err(bus_err)
  );

  assign obs = {inst_req, ir_we, pc_we, pc_src, ext_type, alu_src_b, alu_op,
                data_req, data_wr, reg_we, reg_dst, wb_sel, ri_excp, bus_err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_row(input logic [5:0] o, input logic [5:0] f, input int k,
                         input logic [1:0] ext, input logic srcb, input logic [3:0] aop);
    row_t r;
    r.rop = o; r.rfn = f; r.kind = k; r.ext = ext; r.srcb = srcb; r.aop = aop;
    tbl.push_back(r);
  endtask

  function automatic row_t look(input logic [5:0] o, input logic [5:0] f);
    row_t r;
    r.rop = o; r.rfn = f; r.kind = K_ILL; r.ext = 2'd0; r.srcb = 1'b0; r.aop = 4'd0;
    foreach (tbl[i])
      if (tbl[i].rop == o && (o != 6'h00 || tbl[i].rfn == f)) return tbl[i];
    return r;
  endfunction

  // Inputs are set just after a rising edge; outputs are sampled 3ns later.
  task automatic step(input string tag, input out_t e);
    #3;
    check_eq(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_acks();
    inst_ok = 1'($urandom);
    data_ok = 1'($urandom);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fd, input int md);
    out_t e;
    row_t r;
    for (int i = 0; i <= TO; i++) begin
      op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      data_ok = 1'($urandom);
      inst_ok = (i == fd);
      e = '0; e.ireq = 1'b1;
      if (i == fd) begin
        e.irwe = 1'b1; e.pcwe = 1'b1;
        step($sformatf("fetch_ack op%02h", o), e);
        break;
      end
      if (i == TO) begin
        e.be = 1'b1; e.pcwe = 1'b1; e.pcs = 2'b11;
        step("fetch_timeout", e);
        return;
      end
      step("fetch_wait", e);
    end
    r = look(o, f);
    op = o; funct = f; zero = 1'($urandom); rand_acks();
    e = '0;
    if (r.kind == K_J) begin
      e.pcwe = 1'b1; e.pcs = 2'b10;
      step("decode_j", e);
      return;
    end
    step($sformatf("decode op%02h fn%02h", o, f), e);
    if (r.kind == K_ILL) begin
      rand_acks();
      e = '0; e.ri = 1'b1; e.pcwe = 1'b1; e.pcs = 2'b11;
      step($sformatf("trap op%02h fn%02h", o, f), e);
      return;
    end
    rand_acks();
    e = '0; e.ext = r.ext; e.srcb = r.srcb; e.aop = r.aop;
    if (r.kind == K_BR) begin
      zero = z;
      e.pcs = 2'b01;
      e.pcwe = (o == 6'h04) ? z : ~z;
      step($sformatf("exec_br op%02h z%0d", o, z), e);
      return;
    end
    step($sformatf("exec op%02h fn%02h", o, f), e);
    if (r.kind == K_MEM) begin
      for (int i = 0; i <= TO; i++) begin
        inst_ok = 1'($urandom);
        data_ok = (i == md);
        e = '0; e.ext = r.ext; e.srcb = r.srcb; e.aop = r.aop;
        e.dreq = 1'b1; e.dwr = (o == 6'h2B);
        if (i == md) begin
          step($sformatf("mem_ack op%02h", o), e);
          if (o == 6'h2B) return;
          break;
        end
        if (i == TO) begin
          e.be = 1'b1; e.pcwe = 1'b1; e.pcs = 2'b11;
          step("mem_timeout", e);
          return;
        end
        step("mem_wait", e);
      end
    end
    rand_acks();
    e = '0; e.ext = r.ext; e.srcb = r.srcb; e.aop = r.aop;
    e.rwe = 1'b1; e.rdst = (o == 6'h00); e.wsel = (o == 6'h23);
    step($sformatf("wb op%02h fn%02h", o, f), e);
  endtask

  initial begin
    out_t e;
    row_t r;
    logic [5:0] ro, rf;
    add_row(6'h00, 6'h21, K_ALU, 2'd0, 1'b0, 4'd0);
    add_row(6'h00, 6'h23, K_ALU, 2'd0, 1'b0, 4'd1);
    add_row(6'h00, 6'h24, K_ALU, 2'd0, 1'b0, 4'd2);
    add_row(6'h00, 6'h25, K_ALU, 2'd0, 1'b0, 4'd3);
    add_row(6'h00, 6'h2A, K_ALU, 2'd0, 1'b0, 4'd4);
    add_row(6'h00, 6'h2B, K_ALU, 2'd0, 1'b0, 4'd5);
    add_row(6'h09, 6'h00, K_ALU, 2'd0, 1'b1, 4'd0);
    add_row(6'h0C, 6'h00, K_ALU, 2'd1, 1'b1, 4'd2);
    add_row(6'h0D, 6'h00, K_ALU, 2'd1, 1'b1, 4'd3);
    add_row(6'h0F, 6'h00, K_ALU, 2'd2, 1'b1, 4'd6);
    add_row(6'h23, 6'h00, K_MEM, 2'd0, 1'b1, 4'd0);
    add_row(6'h2B, 6'h00, K_MEM, 2'd0, 1'b1, 4'd0);
    add_row(6'h04, 6'h00, K_BR,  2'd0, 1'b0, 4'd1);
    add_row(6'h05, 6'h00, K_BR,  2'd0, 1'b0, 4'd1);
    add_row(6'h02, 6'h00, K_J,   2'd0, 1'b0, 4'd0);
`ifdef MC_CTRL_IMM_CMP_EN
    add_row(6'h0A, 6'h00, K_ALU, 2'd0, 1'b1, 4'd4);
    add_row(6'h0B, 6'h00, K_ALU, 2'd0, 1'b1, 4'd5);
`endif

    resetn = 1'b0;
    op = '0; funct = '0; zero = 1'b0; inst_ok = 1'b0; data_ok = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_acks(); op = 6'($urandom);
      step("reset", '0);
    end
    resetn = 1'b1;
    rand_acks();
    step("idle", '0);

    run_instr(6'h0D, 6'h15, 1'b0, 2, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 5);
    run_instr(6'h2B, 6'h07, 1'b0, 1, 5);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    run_instr(6'h0A, 6'h00, 1'b0, 0, 0);
    run_instr(6'h0B, 6'h00, 1'b0, 1, 0);
    run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
    run_instr(6'h00, 6'h23, 1'b0, 0, 0);
    run_instr(6'h0F, 6'h00, 1'b0, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 1, 0);
    run_instr(6'h09, 6'h00, 1'b0, TO + 1, 0);
    run_instr(6'h0C, 6'h00, 1'b0, TO, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, TO + 1);
    run_instr(6'h2B, 6'h00, 1'b0, 0, TO);

    // Walk a lw into MEM, then pull reset in the middle of that cycle.
    op = 6'($urandom); inst_ok = 1'b1; data_ok = 1'b0;
    e = '0; e.ireq = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
    step("rst_fetch", e);
    op = 6'h23; inst_ok = 1'b0;
    step("rst_decode", '0);
    e = '0; e.srcb = 1'b1;
    step("rst_exec", e);
    #3;
    check_eq("rst_mem_req", 32'(data_req), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("rst_async_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    data_ok = 1'b1;
    step("rst_held", '0);
    resetn = 1'b1; data_ok = 1'b0;
    step("rst_idle", '0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ro = 6'($urandom); rf = 6'($urandom);
      end else begin
        r = tbl[$urandom_range(0, tbl.size() - 1)];
        ro = r.rop;
        rf = (r.rop == 6'h00) ? r.rfn : 6'($urandom);
      end
      run_instr(ro, rf, 1'($urandom),
                ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO)),
                ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
